// File: rtl/ysyx_22050535_exu_seq_pkg.sv
// Shared decode constants, FSM encoding and M-extension corner-case results for the execute unit.
// The MUL/DIV states exist only when YSYX_22050535_EXU_MDU_EN is defined.
package ysyx_22050535_exu_seq_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;

  // Widest datapath is 64 bits; narrower builds take the low XLEN bits.
  localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OVF_REM   = 64'h0;

`ifdef YSYX_22050535_EXU_MDU_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/ysyx_22050535_exu_seq_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle (YSYX_22050535_EXU_MDU_EN).
// start loads counter=XLEN; done is high the cycle after the last iteration; kill aborts.
`ifdef YSYX_22050535_EXU_MDU_EN
module ysyx_22050535_mdu_iter
  import ysyx_22050535_exu_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi, lo, opd;
  logic [2:0]       f3;
  logic             neg_q, neg_r;

  logic            sa, sb, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ok;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  // Signedness per op: DIV/REM signed, MULH signed x signed, MULHSU signed x unsigned.
  always_comb begin
    if (func3[2]) begin
      sa = !func3[0];
      sb = !func3[0];
    end else begin
      sa = (func3 == F3_MULH) || (func3 == F3_MULHSU);
      sb = (func3 == F3_MULH);
    end
  end

  assign neg_a = sa && src1[XLEN-1];
  assign neg_b = sb && src2[XLEN-1];
  assign mag_a = neg_a ? (~src1 + 1'b1) : src1;
  assign mag_b = neg_b ? (~src2 + 1'b1) : src2;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opd};
  assign div_ok   = !div_diff[XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opd   <= '0;
      f3    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CNT_W'(XLEN);
      hi    <= '0;
      lo    <= mag_a;
      opd   <= mag_b;
      f3    <= func3;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
        if (f3[2]) begin
          hi <= div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], div_ok};
        end else begin
          hi <= mul_sum[XLEN:1];
          lo <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (cnt == '0);

  // Sign fix-up on the magnitude result.
  assign prod     = {hi, lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quot_fix = neg_q ? (~lo + 1'b1) : lo;
  assign rem_fix  = neg_r ? (~hi + 1'b1) : hi;

  always_comb begin
    if (f3[2])
      result = f3[1] ? rem_fix : quot_fix;
    else if (f3 == F3_MUL)
      result = prod_fix[XLEN-1:0];
    else
      result = prod_fix[2*XLEN-1:XLEN];
  end

endmodule
`endif

// File: rtl/ysyx_22050535_exu_seq.sv
// Registered execute unit (ALU, branch compare, optional M extension via YSYX_22050535_EXU_MDU_EN).
// Latency 1 (M ops XLEN+1); holds the result until out_ready, accepting nothing meanwhile.
module ysyx_22050535_exu_seq
  import ysyx_22050535_exu_seq_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int CNT_W   = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_func3,
  input  logic [6:0]      in_func7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_branch_taken,
  output logic            out_illegal
);

  state_e state, state_n;

  logic            is_opimm, is_op, is_br, f7_base, f7_alt, f7_md, sr_alt;
  logic [XLEN-1:0] op_b, alu_res, sra_res;
  logic [SHAMT_W-1:0] shamt;
  logic            lt_s, lt_u, res_taken, res_illegal, m_iter, load_alu;

  assign is_opimm = (in_opcode == OP_IMM);
  assign is_op    = (in_opcode == OP);
  assign is_br    = (in_opcode == BRANCH);
  assign f7_base  = (in_func7 == F7_BASE);
  assign f7_alt   = (in_func7 == F7_ALT);
  assign f7_md    = (in_func7 == F7_MULDIV);

  assign op_b    = is_opimm ? in_imm : in_src2;
  assign shamt   = op_b[SHAMT_W-1:0];
  assign sr_alt  = is_opimm ? in_imm[10] : f7_alt;
  assign sra_res = $signed(in_src1) >>> shamt;
  assign lt_s    = $signed(in_src1) < $signed(op_b);
  assign lt_u    = in_src1 < op_b;

`ifdef YSYX_22050535_EXU_MDU_EN
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic            div_zero, div_ovf, mdu_start, mdu_done, load_mdu;
  logic [XLEN-1:0] mdu_res;

  assign div_zero = in_func3[2] && (in_src2 == '0);
  assign div_ovf  = in_func3[2] && !in_func3[0] && (in_src1 == XMIN) && (in_src2 == '1);

  ysyx_22050535_mdu_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (flush),
    .start  (mdu_start),
    .func3  (in_func3),
    .src1   (in_src1),
    .src2   (in_src2),
    .done   (mdu_done),
    .result (mdu_res)
  );
`else
  localparam int cnt_w_unused = CNT_W;
`endif

  always_comb begin
    alu_res     = '0;
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    m_iter      = 1'b0;
    case (in_func3)
      F3_ADD:  alu_res = (is_op && f7_alt) ? (in_src1 - op_b) : (in_src1 + op_b);
      F3_SLL:  alu_res = in_src1 << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  alu_res = in_src1 ^ op_b;
      F3_SR:   alu_res = sr_alt ? sra_res : (in_src1 >> shamt);
      F3_OR:   alu_res = in_src1 | op_b;
      default: alu_res = in_src1 & op_b;
    endcase
    if (is_br) begin
      alu_res = '0;
      case (in_func3)
        F3_BEQ:  res_taken = (in_src1 == in_src2);
        F3_BNE:  res_taken = (in_src1 != in_src2);
        F3_BLT:  res_taken = lt_s;
        F3_BGE:  res_taken = !lt_s;
        F3_BLTU: res_taken = lt_u;
        F3_BGEU: res_taken = !lt_u;
        default: res_illegal = 1'b1;
      endcase
    end else if (is_op && f7_md) begin
`ifdef YSYX_22050535_EXU_MDU_EN
      // Division corner cases finish in one cycle without the iterative engine.
      if (div_zero)
        alu_res = in_func3[1] ? in_src1 : DIV0_QUOT[XLEN-1:0];
      else if (div_ovf)
        alu_res = in_func3[1] ? OVF_REM[XLEN-1:0] : XMIN;
      else
        m_iter = 1'b1;
`else
      res_illegal = 1'b1;
`endif
    end else if (!(is_opimm || (is_op && (f7_base || f7_alt)))) begin
      res_illegal = 1'b1;
    end
    if (res_illegal)
      alu_res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load_alu = 1'b0;
`ifdef YSYX_22050535_EXU_MDU_EN
    mdu_start = 1'b0;
    load_mdu  = 1'b0;
`endif
    if (flush) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
`ifdef YSYX_22050535_EXU_MDU_EN
            if (m_iter) begin
              mdu_start = 1'b1;
              state_n   = in_func3[2] ? ST_DIV : ST_MUL;
            end else
`endif
            begin
              load_alu = 1'b1;
              state_n  = ST_HOLD;
            end
          end
        end
`ifdef YSYX_22050535_EXU_MDU_EN
        ST_MUL, ST_DIV: begin
          if (mdu_done) begin
            load_mdu = 1'b1;
            state_n  = ST_HOLD;
          end
        end
`endif
        ST_HOLD: if (out_ready) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result       <= '0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (load_alu) begin
      out_result       <= alu_res;
      out_branch_taken <= res_taken;
      out_illegal      <= res_illegal;
    end
`ifdef YSYX_22050535_EXU_MDU_EN
    else if (load_mdu) begin
      out_result       <= mdu_res;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end
`endif
  end

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = (state == ST_IDLE) && !out_valid;

endmodule

// File: tb/tb_ysyx_22050535_exu_seq.sv
// Directed vector bench for ysyx_22050535_exu_seq at XLEN=32; M-extension sequences under YSYX_22050535_EXU_MDU_EN.
module tb_ysyx_22050535_exu_seq;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_src1, in_src2, in_imm, out_result;
  logic [6:0]  in_opcode, in_func7;
  logic [2:0]  in_func3;
  logic        out_branch_taken, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050535_exu_seq #(.XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_src1          (in_src1),
    .in_src2          (in_src2),
    .in_imm           (in_imm),
    .in_opcode        (in_opcode),
    .in_func3         (in_func3),
    .in_func7         (in_func7),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] s1, s2, imm, res;
    logic        tk, ill;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] BRA = 7'b1100011;

  function automatic vec_t mk(input string n, input logic [6:0] o, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] imm, input logic [31:0] res, input logic tk,
                              input logic ill);
    vec_t v;
    v.name = n; v.opc = o; v.f3 = f3; v.f7 = f7; v.s1 = s1; v.s2 = s2;
    v.imm = imm; v.res = res; v.tk = tk; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm);
    in_valid = 1'b1; in_opcode = o; in_func3 = f3; in_func7 = f7;
    in_src1 = s1; in_src2 = s2; in_imm = imm;
  endtask

`ifdef YSYX_22050535_EXU_MDU_EN
  // Issue an iterative M op and require out_valid exactly 33 cycles after accept.
  task automatic run_mdu(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int  cyc;
    bit  rdy_seen;
    @(negedge clk);
    drive(OPR, f3, 7'b0000001, a, b, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    rdy_seen = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1;
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, cyc, 33);
    chk({name, " in_ready low while busy"}, {31'b0, rdy_seen}, 0);
    chk({name, " result"}, out_result, exp);
  endtask
`endif

  initial begin
    vecs.push_back(mk("ADDI",   OPI, 3'b000, 7'h00, 32'h0000_0005, 32'h0000_1234, 32'hFFFF_FFFD, 32'h0000_0002, 0, 0));
    vecs.push_back(mk("ADD",    OPR, 3'b000, 7'h00, 32'h0000_0007, 32'h0000_0008, 32'h0000_0400, 32'h0000_000F, 0, 0));
    vecs.push_back(mk("SUB",    OPR, 3'b000, 7'h20, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFE, 0, 0));
    vecs.push_back(mk("SLL",    OPR, 3'b001, 7'h00, 32'h0000_0001, 32'h0000_0021, 32'h0000_0000, 32'h0000_0002, 0, 0));
    vecs.push_back(mk("SRA",    OPR, 3'b101, 7'h20, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 32'hF800_0000, 0, 0));
    vecs.push_back(mk("SRL",    OPR, 3'b101, 7'h00, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 32'h0800_0000, 0, 0));
    vecs.push_back(mk("SRAI",   OPI, 3'b101, 7'h00, 32'hF000_0000, 32'h0000_0000, 32'h0000_0404, 32'hFF00_0000, 0, 0));
    vecs.push_back(mk("SRLI",   OPI, 3'b101, 7'h00, 32'hF000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0F00_0000, 0, 0));
    vecs.push_back(mk("SLT",    OPR, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 0, 0));
    vecs.push_back(mk("SLTU",   OPR, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 0, 0));
    vecs.push_back(mk("SLTIU",  OPI, 3'b011, 7'h00, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0));
    vecs.push_back(mk("XOR",    OPR, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 32'h0FF0_0FF0, 0, 0));
    vecs.push_back(mk("OR",     OPR, 3'b110, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 32'hFFF0_FFF0, 0, 0));
    vecs.push_back(mk("AND",    OPR, 3'b111, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 32'hF000_F000, 0, 0));
    vecs.push_back(mk("ANDI",   OPI, 3'b111, 7'h00, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_F0FF, 32'h1234_5078, 0, 0));
    vecs.push_back(mk("BLTU",   BRA, 3'b110, 7'h00, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_0000, 1, 0));
    vecs.push_back(mk("BLT",    BRA, 3'b100, 7'h00, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_0000, 0, 0));
    vecs.push_back(mk("BEQ",    BRA, 3'b000, 7'h00, 32'h0000_0005, 32'h0000_0005, 32'h0000_0010, 32'h0000_0000, 1, 0));
    vecs.push_back(mk("BNE",    BRA, 3'b001, 7'h00, 32'h0000_0005, 32'h0000_0005, 32'h0000_0010, 32'h0000_0000, 0, 0));
    vecs.push_back(mk("BGE",    BRA, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0010, 32'h0000_0000, 0, 0));
    vecs.push_back(mk("BGEU",   BRA, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0010, 32'h0000_0000, 1, 0));
    vecs.push_back(mk("BR_F3_010", BRA, 3'b010, 7'h00, 32'h0000_0005, 32'h0000_0005, 32'h0, 32'h0000_0000, 0, 1));
    vecs.push_back(mk("OP_F7_BAD", OPR, 3'b000, 7'h02, 32'h0000_0005, 32'h0000_0005, 32'h0, 32'h0000_0000, 0, 1));
    vecs.push_back(mk("LUI_OPC",   7'b0110111, 3'b000, 7'h00, 32'h5, 32'h5, 32'h0, 32'h0000_0000, 0, 1));
`ifdef YSYX_22050535_EXU_MDU_EN
    vecs.push_back(mk("DIV_OVF", OPR, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0));
    vecs.push_back(mk("REM_OVF", OPR, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk("DIVU_0",  OPR, 3'b101, 7'h01, 32'h0000_0007, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk("REM_0",   OPR, 3'b110, 7'h01, 32'h0000_0007, 32'h0000_0000, 32'h0, 32'h0000_0007, 0, 0));
`else
    vecs.push_back(mk("MUL_NO_MDU", OPR, 3'b000, 7'h01, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0000_0000, 0, 1));
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_src1 = '0; in_src2 = '0; in_imm = '0; in_opcode = '0; in_func3 = '0; in_func7 = '0;

    // Reset values.
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst out_result", out_result, 0);
    chk("rst taken", {31'b0, out_branch_taken}, 0);
    chk("rst illegal", {31'b0, out_illegal}, 0);
    chk("rst in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].s1, vecs[i].s2, vecs[i].imm);
      chk({vecs[i].name, " in_ready"}, {31'b0, in_ready}, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({vecs[i].name, " out_valid"}, {31'b0, out_valid}, 1);
      chk({vecs[i].name, " result"}, out_result, vecs[i].res);
      chk({vecs[i].name, " taken"}, {31'b0, out_branch_taken}, {31'b0, vecs[i].tk});
      chk({vecs[i].name, " illegal"}, {31'b0, out_illegal}, {31'b0, vecs[i].ill});
    end

    // Backpressure: hold 5 cycles while another op is offered.
    @(negedge clk);
    out_ready = 1'b0;
    drive(OPR, 3'b000, 7'h00, 32'h1, 32'h2, 32'h0);
    @(negedge clk);
    drive(OPR, 3'b000, 7'h00, 32'h10, 32'h20, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid", {31'b0, out_valid}, 1);
      chk("bp result", out_result, 32'h3);
      chk("bp in_ready", {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp after xfer out_valid", {31'b0, out_valid}, 0);
    chk("bp after xfer in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    chk("bp no phantom", {31'b0, out_valid}, 0);

    // Flush a pending output while a new op is offered.
    out_ready = 1'b0;
    drive(OPR, 3'b000, 7'h00, 32'h4, 32'h4, 32'h0);
    @(negedge clk);
    chk("fl pending", {31'b0, out_valid}, 1);
    flush = 1'b1;
    drive(OPR, 3'b000, 7'h00, 32'h9, 32'h9, 32'h0);
    @(negedge clk);
    chk("fl out_valid", {31'b0, out_valid}, 0);
    chk("fl in_ready", {31'b0, in_ready}, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl not accepted", {31'b0, out_valid}, 0);

    // Asynchronous reset with a result pending.
    drive(OPR, 3'b000, 7'h00, 32'h4, 32'h5, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar pending", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("ar out_valid", {31'b0, out_valid}, 0);
    chk("ar out_result", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef YSYX_22050535_EXU_MDU_EN
    run_mdu("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_mdu("MUL",  3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB);
    run_mdu("DIV",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run_mdu("REM",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    begin
      bit seen;
      @(negedge clk);
      drive(OPR, 3'b101, 7'h01, 32'd100, 32'd7, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("mdu flush in_ready", {31'b0, in_ready}, 1);
      seen = 0;
      repeat (40) begin
        if (out_valid) seen = 1;
        @(negedge clk);
      end
      chk("mdu flush no output", {31'b0, seen}, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
